// File: rtl/dp_ram_batch_pkg.sv
// Shared types and memory-map helpers for the dual-port RAM batch controller.
package dp_ram_batch_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_RD_REQ, S_LATCH, S_WAIT_MUL, S_WR_OUT,
    S_WR_STAT, S_ERR_STAT, S_ACK_RD, S_ACK_CHK, S_CLR_STAT, S_CLR_CTRL
  } state_t;

  localparam int CTRL_ADDR     = 0;
  localparam int CTRL_GO_BIT   = 0;
  localparam int CTRL_ACK_BIT  = 1;
  localparam int CTRL_N_LSB    = 4;
  localparam int CTRL_N_W      = 4;
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_JOBS_LSB = 8;

  function automatic int in_base_addr(int max_jobs);
    return (max_jobs > 0) ? 1 : 1;
  endfunction

  function automatic int out_base_addr(int max_jobs);
    return 1 + max_jobs;
  endfunction

  function automatic int stat_addr(int max_jobs);
    return 1 + 2 * max_jobs;
  endfunction

  function automatic logic [31:0] stat_word(logic [7:0] jobs, logic err, logic done);
    logic [31:0] w;
    w = '0;
    w[STAT_JOBS_LSB +: 8] = jobs;
    w[STAT_ERR_BIT]       = err;
    w[STAT_DONE_BIT]      = done;
    return w;
  endfunction

endpackage

// File: rtl/dp_ram_batch_controller_if.sv
// RAM-port and multiplier-port signals of the batch controller; master = controller side.
interface dp_ram_batch_controller_if #(
  parameter int OP_W   = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] ADDR;
  logic              WRITE_F;
  logic [31:0]       WRITE_DATA;
  logic [31:0]       READ_DATA;
  logic [3:0]        BYTE_ENABLE;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic              start;
  logic              done;
  logic [2*OP_W-1:0] Y;

  modport master (
    output ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, A, B, start,
    input  READ_DATA, done, Y
  );

  modport slave (
    input  ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, A, B, start,
    output READ_DATA, done, Y
  );
endinterface

// File: rtl/dp_ram_batch_controller.sv
// Batch controller: polls CTRL in shared RAM, runs N operand pairs through the multiplier,
// writes products and STATUS, then waits for HPS ACK. Optional watchdog: DPRC_TIMEOUT_EN.
module dp_ram_batch_controller
  import dp_ram_batch_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int ADDR_W      = 4,
  parameter int MAX_JOBS    = 4,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       CLK,
  input  logic                       RESET,
  dp_ram_batch_controller_if.master  bus,
  output logic                       busy
);

  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] IN_A      = ADDR_W'(in_base_addr(MAX_JOBS));
  localparam logic [ADDR_W-1:0] OUT_A     = ADDR_W'(out_base_addr(MAX_JOBS));
  localparam logic [ADDR_W-1:0] STAT_A    = ADDR_W'(stat_addr(MAX_JOBS));
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [7:0]        MAX_N     = 8'(MAX_JOBS);

  state_t            state_reg, state_next;
  logic [1:0]        wait_reg;
  logic [7:0]        idx_reg, n_reg;
  logic [OP_W-1:0]   a_reg, b_reg;
  logic [2*OP_W-1:0] y_reg;
  logic              start_reg, busy_reg;
  logic [ADDR_W-1:0] addr;
  logic              write_f;
  logic [31:0]       write_data;
  logic [7:0]        ctrl_n;
  logic              ctrl_go, ctrl_ack, n_ok, wait_done, last_job, timed_out;

  assign ctrl_go   = bus.READ_DATA[CTRL_GO_BIT];
  assign ctrl_ack  = bus.READ_DATA[CTRL_ACK_BIT];
  assign ctrl_n    = 8'(bus.READ_DATA[CTRL_N_LSB +: CTRL_N_W]);
  assign n_ok      = (ctrl_n != 8'd0) && (ctrl_n <= MAX_N);
  assign wait_done = (wait_reg == WAIT_LAST);
  assign last_job  = (idx_reg == n_reg - 8'd1);

`ifdef DPRC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_reg;
  logic             unused_ok;

  always_ff @(posedge CLK) begin
    if (!RESET)                     tmo_reg <= '0;
    else if (state_reg == S_LATCH)  tmo_reg <= '0;
    else if (state_reg == S_WAIT_MUL) tmo_reg <= tmo_reg + TMO_W'(1);
  end

  assign timed_out = (state_reg == S_WAIT_MUL) && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));
  assign unused_ok = ^bus.READ_DATA;
`else
  logic unused_ok;
  assign timed_out = 1'b0;
  assign unused_ok = ^{bus.READ_DATA, 32'(TIMEOUT_CYC)};
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (wait_done) state_next = S_CHK;
      S_CHK:      if (!ctrl_go) state_next = S_IDLE;
                  else          state_next = n_ok ? S_RD_REQ : S_ERR_STAT;
      S_RD_REQ:   if (wait_done) state_next = S_LATCH;
      S_LATCH:    state_next = S_WAIT_MUL;
      S_WAIT_MUL: if (bus.done)      state_next = S_WR_OUT;
                  else if (timed_out) state_next = S_ERR_STAT;
      S_WR_OUT:   state_next = last_job ? S_WR_STAT : S_RD_REQ;
      S_WR_STAT,
      S_ERR_STAT: state_next = S_ACK_RD;
      S_ACK_RD:   if (wait_done) state_next = S_ACK_CHK;
      S_ACK_CHK:  state_next = ctrl_ack ? S_CLR_STAT : S_ACK_RD;
      S_CLR_STAT: state_next = S_CLR_CTRL;
      S_CLR_CTRL: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Bus outputs are a pure decode of the state; write data is forced to zero when not writing.
  always_comb begin
    addr       = CTRL_A;
    write_f    = 1'b0;
    write_data = '0;
    case (state_reg)
      S_RD_REQ:   addr = IN_A + ADDR_W'(idx_reg);
      S_WR_OUT:   begin write_f = 1'b1; addr = OUT_A + ADDR_W'(idx_reg); write_data = 32'(y_reg); end
      S_WR_STAT:  begin write_f = 1'b1; addr = STAT_A; write_data = stat_word(n_reg, 1'b0, 1'b1); end
      S_ERR_STAT: begin write_f = 1'b1; addr = STAT_A; write_data = stat_word(idx_reg, 1'b1, 1'b0); end
      S_CLR_STAT: begin write_f = 1'b1; addr = STAT_A; end
      S_CLR_CTRL: begin write_f = 1'b1; addr = CTRL_A; end
      default:    addr = CTRL_A;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      idx_reg   <= '0;
      n_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      y_reg     <= '0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= (state_next != state_reg) ? 2'd0 : wait_reg + 2'd1;
      // Start rises together with the freshly registered operands (first WAIT_MUL cycle).
      start_reg <= (state_reg == S_LATCH);
      case (state_reg)
        S_CHK: begin
          idx_reg <= '0;
          if (ctrl_go && n_ok) begin
            n_reg    <= ctrl_n;
            busy_reg <= 1'b1;
          end
        end
        S_LATCH: begin
          a_reg <= bus.READ_DATA[OP_W-1:0];
          b_reg <= bus.READ_DATA[2*OP_W-1:OP_W];
        end
        S_WAIT_MUL: if (bus.done) y_reg <= bus.Y;
        S_WR_OUT:   if (!last_job) idx_reg <= idx_reg + 8'd1;
        S_CLR_CTRL: busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ADDR        = addr;
  assign bus.WRITE_F     = write_f;
  assign bus.WRITE_DATA  = write_data;
  assign bus.BYTE_ENABLE = 4'hF;
  assign bus.A           = a_reg;
  assign bus.B           = b_reg;
  assign bus.start       = start_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_dp_ram_batch_controller.sv
// Scoreboard bench for dp_ram_batch_controller with a dual-port RAM model and a 3-cycle multiplier.
module tb_dp_ram_batch_controller;

  localparam int OP_W    = 4;
  localparam int ADDR_W  = 4;
  localparam int MUL_LAT = 3;
  localparam logic [3:0] CTRL = 4'd0;
  localparam logic [3:0] STAT = 4'd9;

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic busy;

  dp_ram_batch_controller_if #(.OP_W(OP_W), .ADDR_W(ADDR_W)) bus ();

  dp_ram_batch_controller #(
    .OP_W(OP_W), .ADDR_W(ADDR_W), .MAX_JOBS(4), .RD_LAT(1), .TIMEOUT_CYC(255)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Dual-port RAM: FPGA port from the DUT, HPS port from the bench; registered read.
  logic [31:0] mem [16];
  logic        hps_we = 1'b0;
  logic [3:0]  hps_addr = '0;
  logic [31:0] hps_wdata = '0;
  logic [31:0] rd_q;

  always @(posedge CLK) begin
    if (bus.WRITE_F) mem[bus.ADDR] <= bus.WRITE_DATA;
    if (hps_we)      mem[hps_addr] <= hps_wdata;
    rd_q <= mem[bus.ADDR];
  end
  assign bus.READ_DATA = rd_q;

  // Multiplier: product valid MUL_LAT cycles after the start cycle; starts past stall_after are dropped.
  logic [MUL_LAT-1:0] sr;
  logic [7:0]         prod;
  int                 start_cnt = 0;
  int                 stall_after = 1 << 30;

  always @(posedge CLK) begin
    if (!RESET) sr <= '0;
    else        sr <= {sr[MUL_LAT-2:0], bus.start && (start_cnt < stall_after)};
    if (bus.start) begin
      start_cnt <= start_cnt + 1;
      if (start_cnt < stall_after) prod <= 8'(bus.A) * 8'(bus.B);
    end
  end
  assign bus.done = sr[MUL_LAT-1];
  assign bus.Y    = prod;

  wr_t        exp_wr[$];
  logic [7:0] exp_op[$];
  int n_chk = 0, n_pass = 0;
  int wr_count = 0, wd_viol = 0, nonctrl = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic monitor();
    wr_t        w;
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (bus.WRITE_F) begin
          wr_count++;
          $display("write addr=%0d data=0x%08h", bus.ADDR, bus.WRITE_DATA);
          check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", 32'(bus.ADDR), 32'(w.a));
            check("wr_data", bus.WRITE_DATA, w.d);
          end
        end else if (bus.WRITE_DATA != 32'd0) begin
          wd_viol++;
        end
        if (bus.start) begin
          $display("start A=%0d B=%0d", bus.A, bus.B);
          check("start_expected", 32'(exp_op.size() != 0), 32'd1);
          if (exp_op.size() != 0) begin
            e = exp_op.pop_front();
            check("op_A", 32'(bus.A), 32'(e[3:0]));
            check("op_B", 32'(bus.B), 32'(e[7:4]));
          end
        end
        if (bus.ADDR != CTRL) nonctrl++;
      end
    end
  endtask

  task automatic hps_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    hps_we = 1'b1; hps_addr = a; hps_wdata = d;
    @(negedge CLK);
    hps_we = 1'b0;
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b);
    exp_op.push_back({b, a});
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_wr.size() + exp_op.size()) != 0 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 32'(exp_wr.size() + exp_op.size()), 32'd0);
    exp_wr.delete();
    exp_op.delete();
  endtask

  task automatic ack_and_clear(input logic [31:0] ctrl_val);
    push_wr(STAT, 32'd0);
    push_wr(CTRL, 32'd0);
    hps_wr(CTRL, ctrl_val | 32'h2);
    drain(50);
    repeat (3) @(negedge CLK);
    check("busy_after_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    int s, base_nc, base_wr;
    fork monitor(); join_none

    // Reset: clear the RAM through the HPS port while the DUT is held.
    for (int i = 0; i < 16; i++) hps_wr(4'(i), 32'd0);
    check("rst_addr",  32'(bus.ADDR), 32'd0);
    check("rst_wf",    32'(bus.WRITE_F), 32'd0);
    check("rst_wdata", bus.WRITE_DATA, 32'd0);
    check("rst_ab",    32'({bus.B, bus.A}), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("byte_en",   32'(bus.BYTE_ENABLE), 32'hF);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);

    // Single job 3*5, then ACK withheld for 100 cycles.
    push_op(4'd3, 4'd5);
    push_wr(4'd5, 32'd15);
    push_wr(STAT, 32'h0101);
    hps_wr(4'd1, 32'h53);
    hps_wr(CTRL, 32'h11);
    drain(100);
    check("t1_busy", 32'(busy), 32'd1);
    base_nc = nonctrl;
    base_wr = wr_count;
    repeat (100) @(negedge CLK);
    check("t6_ctrl_only", 32'(nonctrl - base_nc), 32'd0);
    check("t6_no_writes", 32'(wr_count - base_wr), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    ack_and_clear(32'h11);

    // Four jobs.
    push_op(4'd15, 4'd15); push_op(4'd0, 4'd7); push_op(4'd1, 4'd1); push_op(4'd9, 4'd2);
    push_wr(4'd5, 32'd225); push_wr(4'd6, 32'd0); push_wr(4'd7, 32'd1); push_wr(4'd8, 32'd18);
    push_wr(STAT, 32'h0401);
    hps_wr(4'd1, 32'hFF); hps_wr(4'd2, 32'h70); hps_wr(4'd3, 32'h11); hps_wr(4'd4, 32'h29);
    hps_wr(CTRL, 32'h41);
    drain(300);
    check("t2_busy", 32'(busy), 32'd1);
    ack_and_clear(32'h41);

    // Invalid batch sizes N=0 and N=5.
    s = start_cnt;
    push_wr(STAT, 32'h0002);
    hps_wr(CTRL, 32'h01);
    drain(100);
    check("t3_n0_busy", 32'(busy), 32'd0);
    ack_and_clear(32'h01);
    push_wr(STAT, 32'h0002);
    hps_wr(CTRL, 32'h51);
    drain(100);
    ack_and_clear(32'h51);
    check("t3_no_start", 32'(start_cnt - s), 32'd0);

    // Reset while job 2 of 3 waits on the multiplier.
    stall_after = start_cnt + 1;
    hps_wr(4'd6, 32'hDEAD);
    hps_wr(4'd1, 32'h32); hps_wr(4'd2, 32'h44); hps_wr(4'd3, 32'h51);
    push_op(4'd2, 4'd3); push_wr(4'd5, 32'd6); push_op(4'd4, 4'd4);
    hps_wr(CTRL, 32'h31);
    drain(100);
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    hps_wr(CTRL, 32'd0);
    check("t5_addr",  32'(bus.ADDR), 32'd0);
    check("t5_wf",    32'(bus.WRITE_F), 32'd0);
    check("t5_wdata", bus.WRITE_DATA, 32'd0);
    check("t5_ab",    32'({bus.B, bus.A}), 32'd0);
    check("t5_start", 32'(bus.start), 32'd0);
    check("t5_busy",  32'(busy), 32'd0);
    RESET = 1'b1;
    stall_after = 1 << 30;
    repeat (10) @(negedge CLK);
    check("t5_word5", mem[5], 32'd6);
    check("t5_word6", mem[6], 32'hDEAD);
    check("t5_stat",  mem[9], 32'd0);

`ifdef DPRC_TIMEOUT_EN
    // Watchdog: job 2 of 3 never completes.
    stall_after = start_cnt + 1;
    hps_wr(4'd1, 32'h33); hps_wr(4'd2, 32'h22); hps_wr(4'd3, 32'h11);
    push_op(4'd3, 4'd3); push_wr(4'd5, 32'd9); push_op(4'd2, 4'd2);
    push_wr(STAT, 32'h0102);
    hps_wr(CTRL, 32'h31);
    drain(600);
    check("t4_word5", mem[5], 32'd9);
    stall_after = 1 << 30;
    ack_and_clear(32'h31);
`endif

    check("wdata_zero_idle", 32'(wd_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
